// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - round-robin turn scheduler for NUM_PLAYERS with throw/flight tracking,
// wait timeout, round counting and a game-over halt.
module turn_scheduler #(
   parameter int NUM_PLAYERS  = 2,
   parameter int TURN_TIMEOUT = 400_000_000,
   parameter int ROUND_W      = 8,
   parameter int IDX_W        = 3
) (
   input  logic                   clk40MHz,
   input  logic                   rst,
   input  logic [NUM_PLAYERS-1:0] throw_flag,
   input  logic [NUM_PLAYERS-1:0] alive,
   input  logic                   game_over,
   output logic [IDX_W-1:0]       turn_idx,
   output logic [NUM_PLAYERS-1:0] turn_onehot,
   output logic                   turn_start,
   output logic                   timeout,
   output logic [ROUND_W-1:0]     round_cnt,
   output logic                   in_flight
);

   localparam int                TMR_W    = $clog2(TURN_TIMEOUT);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TURN_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_PLAYERS - 1);
   localparam logic [IDX_W:0]    NP_EXT   = (IDX_W+1)'(NUM_PLAYERS);
   localparam logic [NUM_PLAYERS-1:0] ONE = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_SELECT, S_WAIT, S_FLIGHT, S_HALT} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [IDX_W-1:0]        r_turn_idx;
   logic [ROUND_W-1:0]      r_round;
   logic [TMR_W-1:0]        r_timer;
   logic [NUM_PLAYERS-1:0]  r_prev;
   logic                    r_start;
   logic                    r_timeout;
   logic                    r_first;

   logic [NUM_PLAYERS-1:0]  w_flag_sh;
   logic [NUM_PLAYERS-1:0]  w_prev_sh;
   logic [NUM_PLAYERS-1:0]  w_alive_sh;
   logic                    w_rise;
   logic                    w_fall;
   logic                    w_act_alive;

   logic [IDX_W:0]          w_cand;
   logic [NUM_PLAYERS-1:0]  w_cand_sh;
   logic                    w_sel_found;
   logic [IDX_W-1:0]        w_sel_idx;
   logic                    w_wrap;

   logic                    w_load;
   logic                    w_start_nxt;
   logic                    w_timeout_nxt;
   logic                    w_round_inc;
   logic                    w_timer_clr;
   logic                    w_timer_inc;

   // Only the active player's bit is ever examined, so other players' edges are invisible.
   assign w_flag_sh   = throw_flag >> r_turn_idx;
   assign w_prev_sh   = r_prev >> r_turn_idx;
   assign w_alive_sh  = alive >> r_turn_idx;
   assign w_rise      = w_flag_sh[0] & ~w_prev_sh[0];
   assign w_fall      = ~w_flag_sh[0] & w_prev_sh[0];
   assign w_act_alive = w_alive_sh[0];

   // Scan candidates from farthest to nearest so the nearest alive index wins; the
   // current index is the final candidate (k = NUM_PLAYERS).
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = r_turn_idx;
      w_cand      = '0;
      w_cand_sh   = '0;
      for (int k = NUM_PLAYERS; k >= 1; k--) begin
         w_cand = {1'b0, r_turn_idx} + (IDX_W+1)'(k);
         if (w_cand >= NP_EXT) begin
            w_cand = w_cand - NP_EXT;
         end
         w_cand_sh = alive >> w_cand;
         if (w_cand_sh[0]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_cand[IDX_W-1:0];
         end
      end
   end

   assign w_wrap = (w_sel_idx <= r_turn_idx);

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         r_state <= S_SELECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_start_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
      w_round_inc   = 1'b0;
      w_timer_clr   = 1'b0;
      w_timer_inc   = 1'b0;
      if (game_over) begin
         w_state_nxt = S_HALT;
      end else begin
         case (r_state)
            S_SELECT: begin
               if (w_sel_found) begin
                  w_state_nxt = S_WAIT;
                  w_load      = 1'b1;
                  w_start_nxt = 1'b1;
                  w_timer_clr = 1'b1;
                  w_round_inc = w_wrap & ~r_first;
               end else begin
                  w_state_nxt = S_HALT;
               end
            end
            S_WAIT: begin
               // A throw in the expiry cycle still counts as a throw.
               if (w_rise) begin
                  w_state_nxt = S_FLIGHT;
               end else if (!w_act_alive) begin
                  w_state_nxt = S_SELECT;
               end else if (r_timer == TMR_LAST) begin
                  w_state_nxt   = S_SELECT;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_timer_inc = 1'b1;
               end
            end
            S_FLIGHT: begin
               if (w_fall) begin
                  w_state_nxt = S_SELECT;
               end
            end
            S_HALT: begin
               w_state_nxt = S_HALT;
            end
            default: begin
               w_state_nxt = S_SELECT;
            end
         endcase
      end
   end

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         r_turn_idx <= IDX_LAST;
         r_round    <= '0;
         r_timer    <= '0;
         r_prev     <= '0;
         r_start    <= 1'b0;
         r_timeout  <= 1'b0;
         r_first    <= 1'b1;
      end else begin
         r_prev    <= throw_flag;
         r_start   <= w_start_nxt;
         r_timeout <= w_timeout_nxt;
         if (w_load) begin
            r_turn_idx <= w_sel_idx;
            r_first    <= 1'b0;
         end
         if (w_round_inc) begin
            r_round <= r_round + ROUND_W'(1);
         end
         if (w_timer_clr) begin
            r_timer <= '0;
         end else if (w_timer_inc) begin
            r_timer <= r_timer + TMR_W'(1);
         end
      end
   end

   assign turn_idx    = r_turn_idx;
   assign turn_onehot = (r_state == S_HALT) ? '0 : (ONE << r_turn_idx);
   assign turn_start  = r_start;
   assign timeout     = r_timeout;
   assign round_cnt   = r_round;
   assign in_flight   = (r_state == S_FLIGHT);

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - directed self-checking bench for turn_scheduler (4 players, timeout 16).
module tb_turn_scheduler;

   logic       clk40MHz = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] throw_flag = 4'b0000;
   logic [3:0] alive = 4'b1111;
   logic       game_over = 1'b0;
   logic [2:0] turn_idx;
   logic [3:0] turn_onehot;
   logic       turn_start;
   logic       timeout;
   logic [3:0] round_cnt;
   logic       in_flight;

   int n_vec = 0;
   int n_bad = 0;

   turn_scheduler #(
      .NUM_PLAYERS  (4),
      .TURN_TIMEOUT (16),
      .ROUND_W      (4),
      .IDX_W        (3)
   ) dut (
      .clk40MHz    (clk40MHz),
      .rst         (rst),
      .throw_flag  (throw_flag),
      .alive       (alive),
      .game_over   (game_over),
      .turn_idx    (turn_idx),
      .turn_onehot (turn_onehot),
      .turn_start  (turn_start),
      .timeout     (timeout),
      .round_cnt   (round_cnt),
      .in_flight   (in_flight)
   );

   always #5 clk40MHz = ~clk40MHz;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk40MHz);
      #1;
   endtask

   task automatic throw_turn(input int p);
      throw_flag[p] = 1'b1;
      tick;
      throw_flag[p] = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      n_vec++; if (turn_idx !== 3'd3) begin n_bad++; $display("FAIL rst_idx: got %0d want 3", turn_idx); end
      n_vec++; if (turn_onehot !== 4'b1000) begin n_bad++; $display("FAIL rst_onehot: got %b want 1000", turn_onehot); end
      n_vec++; if (round_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_round: got %0d want 0", round_cnt); end
      n_vec++; if ({turn_start, timeout, in_flight} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {turn_start, timeout, in_flight}); end
      rst = 1'b0;
      tick;
      n_vec++; if (turn_idx !== 3'd0) begin n_bad++; $display("FAIL first_idx: got %0d want 0", turn_idx); end
      n_vec++; if (turn_start !== 1'b1) begin n_bad++; $display("FAIL first_start: got %b want 1", turn_start); end
      n_vec++; if (turn_onehot !== 4'b0001) begin n_bad++; $display("FAIL first_onehot: got %b want 0001", turn_onehot); end
      n_vec++; if (round_cnt !== 4'd0) begin n_bad++; $display("FAIL first_round: got %0d want 0", round_cnt); end
      tick;
      n_vec++; if (turn_start !== 1'b0) begin n_bad++; $display("FAIL start_pulse_width: got %b want 0", turn_start); end
   endtask

   task automatic test_first_throw;
      throw_flag[0] = 1'b1;
      repeat (5) tick;
      n_vec++; if (in_flight !== 1'b1) begin n_bad++; $display("FAIL flight_enter: got %b want 1", in_flight); end
      throw_flag[0] = 1'b0;
      tick;
      n_vec++; if ({turn_idx, turn_start} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL fall_plus1: got idx %0d start %b want idx 0 start 0", turn_idx, turn_start); end
      tick;
      n_vec++; if ({turn_idx, turn_start} !== {3'd1, 1'b1}) begin n_bad++; $display("FAIL fall_plus2: got idx %0d start %b want idx 1 start 1", turn_idx, turn_start); end
      n_vec++; if (round_cnt !== 4'd0) begin n_bad++; $display("FAIL after_first_round: got %0d want 0", round_cnt); end
   endtask

   task automatic test_rotation;
      throw_turn(1);
      n_vec++; if (turn_idx !== 3'd2) begin n_bad++; $display("FAIL rot_idx2: got %0d want 2", turn_idx); end
      throw_turn(2);
      n_vec++; if ({turn_idx, round_cnt} !== {3'd3, 4'd0}) begin n_bad++; $display("FAIL rot_idx3: got idx %0d round %0d want 3/0", turn_idx, round_cnt); end
      throw_turn(3);
      n_vec++; if ({turn_idx, round_cnt, turn_start} !== {3'd0, 4'd1, 1'b1}) begin n_bad++; $display("FAIL rot_wrap: got idx %0d round %0d start %b want 0/1/1", turn_idx, round_cnt, turn_start); end
   endtask

   task automatic test_round_wrap;
      for (int r = 0; r < 14; r++) begin
         for (int p = 0; p < 4; p++) throw_turn(p);
      end
      n_vec++; if ({turn_idx, round_cnt} !== {3'd0, 4'd15}) begin n_bad++; $display("FAIL round_15: got idx %0d round %0d want 0/15", turn_idx, round_cnt); end
      for (int p = 0; p < 4; p++) throw_turn(p);
      n_vec++; if ({turn_idx, round_cnt} !== {3'd0, 4'd0}) begin n_bad++; $display("FAIL round_wrap: got idx %0d round %0d want 0/0", turn_idx, round_cnt); end
   endtask

   task automatic test_skip;
      alive = 4'b1011;
      throw_turn(0);
      n_vec++; if (turn_idx !== 3'd1) begin n_bad++; $display("FAIL skip_idx1: got %0d want 1", turn_idx); end
      throw_turn(1);
      n_vec++; if ({turn_idx, round_cnt} !== {3'd3, 4'd0}) begin n_bad++; $display("FAIL skip_dead2: got idx %0d round %0d want 3/0", turn_idx, round_cnt); end
      throw_turn(3);
      n_vec++; if ({turn_idx, round_cnt} !== {3'd0, 4'd1}) begin n_bad++; $display("FAIL skip_wrap: got idx %0d round %0d want 0/1", turn_idx, round_cnt); end
   endtask

   task automatic test_single_alive;
      alive = 4'b0001;
      throw_turn(0);
      n_vec++; if ({turn_idx, turn_start, round_cnt} !== {3'd0, 1'b1, 4'd2}) begin n_bad++; $display("FAIL solo_1: got idx %0d start %b round %0d want 0/1/2", turn_idx, turn_start, round_cnt); end
      throw_turn(0);
      n_vec++; if ({turn_idx, round_cnt} !== {3'd0, 4'd3}) begin n_bad++; $display("FAIL solo_2: got idx %0d round %0d want 0/3", turn_idx, round_cnt); end
   endtask

   task automatic test_timeout;
      int pulses;
      int first_at;
      pulses   = 0;
      first_at = -1;
      alive = 4'b1111;
      for (int t = 1; t <= 17; t++) begin
         tick;
         if (timeout === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = t;
         end
      end
      n_vec++; if (pulses != 1) begin n_bad++; $display("FAIL timeout_count: got %0d want 1", pulses); end
      n_vec++; if (first_at != 16) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 16", first_at); end
      n_vec++; if ({turn_idx, turn_start} !== {3'd1, 1'b1}) begin n_bad++; $display("FAIL timeout_advance: got idx %0d start %b want 1/1", turn_idx, turn_start); end
   endtask

   task automatic test_timeout_race;
      int pulses;
      pulses = 0;
      for (int t = 0; t < 15; t++) begin
         tick;
         if (timeout === 1'b1) pulses++;
      end
      throw_flag[1] = 1'b1;
      tick;
      if (timeout === 1'b1) pulses++;
      n_vec++; if (in_flight !== 1'b1) begin n_bad++; $display("FAIL race_flight: got %b want 1", in_flight); end
      tick;
      if (timeout === 1'b1) pulses++;
      n_vec++; if (pulses != 0) begin n_bad++; $display("FAIL race_no_timeout: got %0d pulses want 0", pulses); end
      throw_flag[1] = 1'b0;
      tick;
      tick;
      n_vec++; if ({turn_idx, turn_start} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL race_advance: got idx %0d start %b want 2/1", turn_idx, turn_start); end
   endtask

   task automatic test_simultaneous_fall;
      int starts;
      starts = 0;
      throw_flag[0] = 1'b1;
      tick;
      n_vec++; if (in_flight !== 1'b0) begin n_bad++; $display("FAIL foreign_rise: got %b want 0", in_flight); end
      throw_flag[2] = 1'b1;
      tick;
      n_vec++; if (in_flight !== 1'b1) begin n_bad++; $display("FAIL active_rise: got %b want 1", in_flight); end
      tick;
      throw_flag = 4'b0000;
      tick;
      tick;
      n_vec++; if ({turn_idx, turn_start} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL dual_fall: got idx %0d start %b want 3/1", turn_idx, turn_start); end
      repeat (3) begin
         tick;
         if (turn_start === 1'b1) starts++;
      end
      n_vec++; if ({turn_idx, in_flight} !== {3'd3, 1'b0} || starts != 0) begin n_bad++; $display("FAIL dual_fall_once: got idx %0d flight %b extra starts %0d want 3/0/0", turn_idx, in_flight, starts); end
   endtask

   task automatic test_game_over;
      int ev;
      ev = 0;
      tick;
      game_over = 1'b1;
      tick;
      n_vec++; if ({turn_onehot, turn_idx, turn_start, in_flight} !== {4'b0000, 3'd3, 1'b0, 1'b0}) begin n_bad++; $display("FAIL halt_enter: got onehot %b idx %0d start %b flight %b want 0000/3/0/0", turn_onehot, turn_idx, turn_start, in_flight); end
      game_over = 1'b0;
      throw_flag[3] = 1'b1;
      repeat (20) begin
         tick;
         if (turn_start === 1'b1 || timeout === 1'b1 || in_flight === 1'b1) ev++;
      end
      throw_flag[3] = 1'b0;
      n_vec++; if (ev != 0) begin n_bad++; $display("FAIL halt_quiet: got %0d events want 0", ev); end
      n_vec++; if ({turn_idx, round_cnt, turn_onehot} !== {3'd3, 4'd3, 4'b0000}) begin n_bad++; $display("FAIL halt_frozen: got idx %0d round %0d onehot %b want 3/3/0000", turn_idx, round_cnt, turn_onehot); end
   endtask

   task automatic test_restart;
      rst = 1'b1;
      alive = 4'b0110;
      tick;
      rst = 1'b0;
      tick;
      n_vec++; if ({turn_idx, turn_start, round_cnt, turn_onehot} !== {3'd1, 1'b1, 4'd0, 4'b0010}) begin n_bad++; $display("FAIL restart: got idx %0d start %b round %0d onehot %b want 1/1/0/0010", turn_idx, turn_start, round_cnt, turn_onehot); end
   endtask

   task automatic test_alive_zero;
      alive = 4'b0000;
      tick;
      n_vec++; if ({turn_idx, turn_start, turn_onehot} !== {3'd1, 1'b0, 4'b0010}) begin n_bad++; $display("FAIL dead_to_select: got idx %0d start %b onehot %b want 1/0/0010", turn_idx, turn_start, turn_onehot); end
      tick;
      n_vec++; if ({turn_idx, turn_start, turn_onehot} !== {3'd1, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL none_alive_halt: got idx %0d start %b onehot %b want 1/0/0000", turn_idx, turn_start, turn_onehot); end
   endtask

   task automatic test_reset_mid_flight;
      alive = 4'b1100;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tick;
      n_vec++; if ({turn_idx, turn_start} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL restart_lowest: got idx %0d start %b want 2/1", turn_idx, turn_start); end
      throw_flag[2] = 1'b1;
      tick;
      n_vec++; if (in_flight !== 1'b1) begin n_bad++; $display("FAIL mid_flight_enter: got %b want 1", in_flight); end
      rst = 1'b1;
      throw_flag[2] = 1'b0;
      tick;
      n_vec++; if ({in_flight, turn_start, timeout, turn_idx} !== {1'b0, 1'b0, 1'b0, 3'd3}) begin n_bad++; $display("FAIL abort_flight: got flight %b start %b timeout %b idx %0d want 0/0/0/3", in_flight, turn_start, timeout, turn_idx); end
      rst = 1'b0;
      tick;
      n_vec++; if ({turn_idx, turn_start, round_cnt} !== {3'd2, 1'b1, 4'd0}) begin n_bad++; $display("FAIL abort_restart: got idx %0d start %b round %0d want 2/1/0", turn_idx, turn_start, round_cnt); end
   endtask

   initial begin
      test_reset;
      test_first_throw;
      test_rotation;
      test_round_wrap;
      test_skip;
      test_single_alive;
      test_timeout;
      test_timeout_race;
      test_simultaneous_fall;
      test_game_over;
      test_restart;
      test_alive_zero;
      test_reset_mid_flight;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
